complex_fu_exec: RTL

- Execution unit for the complex (non-simple) instruction path. It consumes the complex-lane packet that the execute-stage simple/complex demux emits.
- Executes PISA MULT/MULTU on a fixed-latency pipeline and DIV/DIVU on an iterative radix-2 divider.
- Returns one 64-bit HI/LO result per cycle toward writeback, tagged for wakeup and active-list completion.
- Supports pipeline flush on branch-mispredict or exception recovery.

---
 rtl/complex_fu_exec.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/complex_fu_exec.sv
`default_nettype none
// ============================================================================
// Module      : complex_fu_exec
// Description : Complex-lane execution unit. MULT/MULTU run on a fixed-latency
//               pipeline; DIV/DIVU run on an iterative radix-2 restoring
//               divider. One tagged 64-bit HI:LO result per cycle is returned
//               toward writeback. Flush kills all in-flight work.
// Revision    : 1.0 - initial release
// ============================================================================
module complex_fu_exec #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 16,
    parameter int MUL_LAT    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_src1,
    input  logic [DATA_WIDTH-1:0] in_src2,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_hi,
    output logic [DATA_WIDTH-1:0] out_lo,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  div_busy
);

    localparam int                C_CNT_W      = $clog2(DATA_WIDTH + 1);
    localparam logic [C_CNT_W-1:0] C_COUNT_INIT = C_CNT_W'(DATA_WIDTH);
    localparam logic [C_CNT_W-1:0] C_COUNT_LAST = C_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    div_state_t r_state;
    div_state_t w_state_next;

    // ------------------------------------------------------------------
    // Input decode / accept
    // ------------------------------------------------------------------
    logic w_accept;
    logic w_mul_accept;
    logic w_div_accept;
    logic w_op_signed;

    // in_op[1] selects the divider, in_op[0] selects the unsigned variant.
    assign w_accept     = in_valid & in_ready & ~flush;
    assign w_mul_accept = w_accept & ~in_op[1];
    assign w_div_accept = w_accept &  in_op[1];
    assign w_op_signed  = ~in_op[0];

    // ------------------------------------------------------------------
    // Multiplier: operands are sign- or zero-extended to full product
    // width so a single unsigned multiply gives the correct low 2W bits.
    // ------------------------------------------------------------------
    logic [2*DATA_WIDTH-1:0] w_mul_a_ext;
    logic [2*DATA_WIDTH-1:0] w_mul_b_ext;
    logic [2*DATA_WIDTH-1:0] w_mul_prod;

    assign w_mul_a_ext = {{DATA_WIDTH{w_op_signed & in_src1[DATA_WIDTH-1]}}, in_src1};
    assign w_mul_b_ext = {{DATA_WIDTH{w_op_signed & in_src2[DATA_WIDTH-1]}}, in_src2};
    assign w_mul_prod  = w_mul_a_ext * w_mul_b_ext;

    logic [MUL_LAT-1:0]      r_mul_vld;
    logic [2*DATA_WIDTH-1:0] r_mul_prod [MUL_LAT];
    logic [TAG_WIDTH-1:0]    r_mul_tag  [MUL_LAT];

    // Multiply pipeline: valid/tag/product advance one stage per cycle,
    // data registers only load behind a valid so the last stage holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                r_mul_vld[k]  <= 1'b0;
                r_mul_prod[k] <= '0;
                r_mul_tag[k]  <= '0;
            end
        end else begin
            // w_mul_accept is already low during a flush
            r_mul_vld[0] <= w_mul_accept;
            if (w_mul_accept) begin
                r_mul_prod[0] <= w_mul_prod;
                r_mul_tag[0]  <= in_tag;
            end
            for (int k = 1; k < MUL_LAT; k++) begin
                r_mul_vld[k] <= r_mul_vld[k-1] & ~flush;
                if (r_mul_vld[k-1]) begin
                    r_mul_prod[k] <= r_mul_prod[k-1];
                    r_mul_tag[k]  <= r_mul_tag[k-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Divider datapath
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_quo;       // dividend magnitude shifting out, quotient shifting in
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_divisor;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic [TAG_WIDTH-1:0]  r_div_tag;
    logic [C_CNT_W-1:0]    r_count;

    logic [DATA_WIDTH-1:0] w_abs_a;
    logic [DATA_WIDTH-1:0] w_abs_b;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH:0]   w_shift_rem;
    logic [DATA_WIDTH-1:0] w_trial;
    logic                  w_ge;

    assign w_a_neg = w_op_signed & in_src1[DATA_WIDTH-1];
    assign w_b_neg = w_op_signed & in_src2[DATA_WIDTH-1];
    assign w_abs_a = w_a_neg ? (~in_src1 + 1'b1) : in_src1;
    assign w_abs_b = w_b_neg ? (~in_src2 + 1'b1) : in_src2;

    // The partial remainder stays below the divisor, so the shifted value
    // fits in W+1 bits and the subtraction result fits in W bits. With a
    // zero divisor every step subtracts nothing: quotient bits all set and
    // the remainder ends up equal to the dividend magnitude.
    assign w_shift_rem = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_ge        = (w_shift_rem >= {1'b0, r_divisor});
    assign w_trial     = w_shift_rem[DATA_WIDTH-1:0] - r_divisor;

    // Divider operand capture on accept, one restoring step per BUSY cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div_tag <= '0;
            r_count   <= '0;
        end else if (w_div_accept) begin
            r_quo     <= w_abs_a;
            r_rem     <= '0;
            r_divisor <= w_abs_b;
            // Divide-by-zero must keep the all-ones quotient unnegated.
            r_neg_q   <= (w_a_neg ^ w_b_neg) & (in_src2 != '0);
            r_neg_r   <= w_a_neg;
            r_div_tag <= in_tag;
            r_count   <= C_COUNT_INIT;
        end else if (r_state == S_BUSY) begin
            r_rem   <= w_ge ? w_trial : w_shift_rem[DATA_WIDTH-1:0];
            r_quo   <= {r_quo[DATA_WIDTH-2:0], w_ge};
            r_count <= r_count - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Divider FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush returns to IDLE from any state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_div_accept)           w_state_next = S_BUSY;
            S_BUSY: if (r_count == C_COUNT_LAST) w_state_next = S_DONE;
            S_DONE:                              w_state_next = S_IDLE;
            default:                             w_state_next = S_IDLE;
        endcase
        if (flush) begin
            w_state_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic                  w_div_done;
    logic [DATA_WIDTH-1:0] w_q_fix;
    logic [DATA_WIDTH-1:0] w_r_fix;

    assign w_div_done = (r_state == S_DONE);
    assign w_q_fix    = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_r_fix    = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    assign in_ready  = (r_state == S_IDLE);
    assign div_busy  = (r_state != S_IDLE);
    assign out_valid = (r_mul_vld[MUL_LAT-1] | w_div_done) & ~flush;
    assign out_hi    = w_div_done ? w_r_fix   : r_mul_prod[MUL_LAT-1][2*DATA_WIDTH-1:DATA_WIDTH];
    assign out_lo    = w_div_done ? w_q_fix   : r_mul_prod[MUL_LAT-1][DATA_WIDTH-1:0];
    assign out_tag   = w_div_done ? r_div_tag : r_mul_tag[MUL_LAT-1];

    // Muls are only accepted in IDLE, so the pipe has drained before DONE.
    a_no_collision : assert property (@(posedge clk) disable iff (reset)
        !(r_mul_vld[MUL_LAT-1] && w_div_done));

endmodule
`default_nettype wire
